// File: rtl/rv_drpif_pkg.sv
// Shared types and register map for the rv_core DRP master.
package rv_drpif_pkg;
  typedef logic [3:0]  u4_t;
  typedef logic [4:0]  u5_t;
  typedef logic [6:0]  u7_t;
  typedef logic [15:0] u16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } drp_state_t;

  localparam u5_t DRP_DATA = 5'h00;
  localparam u5_t DRP_CMD  = 5'h04;
  localparam u5_t DRP_STAT = 5'h08;

  localparam int unsigned CMD_WR_BIT = 8;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_TMO   = 2;
  localparam int unsigned STAT_COLL  = 3;
endpackage

// File: rtl/rv_drpif.sv
// CPU-bus DRP master: software-launched single read/write transactions with drdy
// timeout and sticky done/timeout/collision status.
module rv_drpif
  import rv_drpif_pkg::*;
#(
  parameter int unsigned TMO_CYC = 64
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic [6:0]  daddr_o,
  output logic        den_o,
  output logic        dwe_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic        busy_o
);
  localparam int unsigned      CNT_W    = $clog2(TMO_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  drp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  u16_t             wdata_q, wdata_d, rdata_q, rdata_d, di_q, di_d;
  u7_t              addr_q, addr_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d, tmo_q, tmo_d, coll_q, coll_d;
  logic             den_q, den_d, dwe_q, dwe_d, busy_q, busy_d;
  logic [31:0]      dr_q, dr_d, rd_mux;
  logic             wr_acc, rd_acc, data_wr, cmd_wr, stat_wr, launch;
  logic             unused_dw;

  assign wr_acc  = cs && rdy && (|we);
  assign rd_acc  = cs && re;
  assign data_wr = wr_acc && (adr == DRP_DATA);
  assign cmd_wr  = wr_acc && (adr == DRP_CMD) && we[0];
  assign stat_wr = wr_acc && (adr == DRP_STAT) && we[0];
  assign launch  = cmd_wr && (state_q == IDLE);
  assign unused_dw = ^dw[31:16];

  // State register
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (drdy_i || (cnt_q == CNT_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux over the 32-byte window; unmapped offsets read as zero
  always_comb begin
    rd_mux = '0;
    case (adr)
      DRP_DATA: rd_mux = {16'b0, rdata_q};
      DRP_CMD:  rd_mux = {23'b0, wr_q, 1'b0, addr_q};
      DRP_STAT: rd_mux = {28'b0, coll_q, tmo_q, done_q, busy_q};
      default:  rd_mux = '0;
    endcase
  end

  // Output and datapath next values; status sets are applied after clears so sets win
  always_comb begin
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    di_d    = di_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    coll_d  = coll_q;
    dr_d    = dr_q;

    if (data_wr) begin
      if (we[0]) wdata_d[7:0]  = dw[7:0];
      if (we[1]) wdata_d[15:8] = dw[15:8];
    end
    if (stat_wr) begin
      if (dw[STAT_DONE]) done_d = 1'b0;
      if (dw[STAT_TMO])  tmo_d  = 1'b0;
      if (dw[STAT_COLL]) coll_d = 1'b0;
    end
    if (launch) begin
      addr_d = dw[6:0];
      wr_d   = dw[CMD_WR_BIT];
      di_d   = wdata_q;
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (cmd_wr && (state_q != IDLE)) coll_d = 1'b1;

    if (state_q == REQ) cnt_d = '0;
    if (state_q == WAIT) begin
      if (drdy_i) begin
        done_d = 1'b1;
        if (!wr_q) rdata_d = do_i;
      end else if (cnt_q == CNT_LAST) begin
        tmo_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    den_d  = (state_d == REQ);
    dwe_d  = den_d && wr_d;
    busy_d = (state_d != IDLE);
    if (rdy) dr_d = rd_acc ? rd_mux : 32'b0;
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      di_q    <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      coll_q  <= 1'b0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      busy_q  <= 1'b0;
      dr_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      di_q    <= di_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      coll_q  <= coll_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      busy_q  <= busy_d;
      dr_q    <= dr_d;
    end
  end

  assign dr      = dr_q;
  assign daddr_o = addr_q;
  assign den_o   = den_q;
  assign dwe_o   = dwe_q;
  assign di_o    = di_q;
  assign busy_o  = busy_q;
endmodule

// File: tb/tb_rv_drpif.sv
// Bench for rv_drpif: DRP responder with programmable drdy latency, and a
// transaction-level model of the register file predicting status/data outcomes.
module tb_rv_drpif;
  import rv_drpif_pkg::*;

  localparam int TMO = 64;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        xreset, cs, rdy, re;
  logic [4:0]  adr;
  logic [3:0]  we;
  logic [31:0] dw, dr;
  logic [6:0]  daddr_o;
  logic        den_o, dwe_o, drdy_i, busy_o;
  logic [15:0] di_o, do_i;

  always #5 clk = ~clk;

  rv_drpif #(.TMO_CYC(TMO)) dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr), .daddr_o(daddr_o), .den_o(den_o), .dwe_o(dwe_o), .di_o(di_o),
    .do_i(do_i), .drdy_i(drdy_i), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [15:0] mem_init(input int i);
    return 16'((i * 257) ^ 23100);
  endfunction

  // DRP target: counts enables, stores writes, answers lat cycles after den
  int          lat = 3;
  int          stray_req = 0, stray_done = 0;
  int          den_cnt = 0, dwe_cnt = 0;
  logic [15:0] tgt_mem [128];
  logic [6:0]  last_addr, pend_addr;
  logic [15:0] last_di;
  int          rk;
  bit          pend;

  initial begin : responder
    for (int i = 0; i < 128; i++) tgt_mem[i] = mem_init(i);
    drdy_i = 1'b0; do_i = '0; pend = 1'b0; rk = 0; pend_addr = '0;
    last_addr = '0; last_di = '0;
    forever begin
      @(negedge clk);
      drdy_i = 1'b0;
      if (dwe_o) dwe_cnt++;
      if (den_o) begin
        den_cnt++;
        last_addr = daddr_o;
        last_di   = di_o;
        if (dwe_o) tgt_mem[daddr_o] = di_o;
        pend = 1'b1; rk = 0; pend_addr = daddr_o;
      end else if (pend) begin
        rk++;
        if (rk == lat) begin
          drdy_i = 1'b1; do_i = tgt_mem[pend_addr]; pend = 1'b0;
        end
      end
      if (stray_req != stray_done) begin
        drdy_i = 1'b1; do_i = 16'hDEAD; stray_done = stray_req;
      end
    end
  end

  // Reference model of the software-visible state
  logic [15:0] m_wdata, m_rdata, m_di;
  logic [6:0]  m_addr;
  logic        m_wr, m_done, m_tmo, m_coll;
  logic [15:0] exp_mem [128];

  function automatic int exp_busy(input int l);
    return (l >= 1 && l <= TMO) ? l + 1 : TMO + 1;
  endfunction

  function automatic logic [31:0] m_stat();
    return {28'b0, m_coll, m_tmo, m_done, 1'b0};
  endfunction

  task automatic model_reset();
    m_wdata = '0; m_rdata = '0; m_di = '0; m_addr = '0;
    m_wr = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_coll = 1'b0;
  endtask

  task automatic model_txn(input logic [6:0] a, input bit w, input int l);
    m_addr = a; m_wr = w; m_di = m_wdata; m_done = 1'b0; m_tmo = 1'b0;
    if (w) exp_mem[a] = m_wdata;
    if (l >= 1 && l <= TMO) begin
      m_done = 1'b1;
      if (!w) m_rdata = exp_mem[a];
    end else begin
      m_tmo = 1'b1;
    end
  endtask

  task automatic bus_idle();
    cs = 1'b0; we = '0; re = 1'b0; rdy = 1'b0;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rdy = 1'b1; re = 1'b0; adr = a; we = be; dw = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; rdy = 1'b1; re = 1'b1; we = '0; adr = a;
    @(negedge clk);
    v = dr;
    bus_idle();
  endtask

  task automatic data_wr(input logic [3:0] be, input logic [31:0] d);
    bus_wr(DRP_DATA, be, d);
    if (be != 4'h0) begin
      if (be[0]) m_wdata[7:0]  = d[7:0];
      if (be[1]) m_wdata[15:8] = d[15:8];
    end
  endtask

  // Launch a CMD and count busy cycles; inj: 1=CMD collision, 2=DATA write, 3=STAT clear 0xE
  task automatic launch_and_wait(input logic [6:0] a, input bit w, input int l,
                                 input int inj, input int inj_at,
                                 output int busy_n, output int den_n, output int dwe_n);
    int d0, w0;
    logic [31:0] r;
    lat = l; d0 = den_cnt; w0 = dwe_cnt;
    bus_wr(DRP_CMD, 4'h1, {23'b0, w, 1'b0, a});
    busy_n = 0;
    while (busy_o === 1'b1 && busy_n < 200) begin
      busy_n++;
      r = $urandom;
      if (inj != 0 && busy_n == inj_at) begin
        cs = 1'b1; rdy = 1'b1; we = 4'h1;
        if (inj == 1) begin
          adr = DRP_CMD; dw = r; m_coll = 1'b1;
        end else if (inj == 2) begin
          adr = DRP_DATA; we = 4'h3; dw = r; m_wdata = r[15:0];
        end else begin
          adr = DRP_STAT; dw = 32'hE; m_coll = 1'b0;
        end
      end else begin
        bus_idle();
      end
      @(negedge clk);
    end
    bus_idle();
    den_n = den_cnt - d0;
    dwe_n = dwe_cnt - w0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus_idle(); adr = '0; dw = '0;
    xreset = 1'b1;
    #2 xreset = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({dr, daddr_o, den_o, dwe_o, di_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: dr=%h daddr=%h den=%b dwe=%b di=%h busy=%b, want all 0",
               dr, daddr_o, den_o, dwe_o, di_o, busy_o);
    end
    xreset = 1'b1;
    model_reset();
    for (int i = 0; i < 128; i++) exp_mem[i] = mem_init(i);
    bus_rd(DRP_DATA, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", v); end
    bus_rd(DRP_CMD, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", v); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_stat: got %h want 0", v); end
    bus_rd(5'h0C, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", v); end
  endtask

  task automatic test_write();
    int b, d, wc;
    logic [31:0] v;
    data_wr(4'h3, 32'h0000_1234);
    model_txn(7'h41, 1'b1, 3);
    launch_and_wait(7'h41, 1'b1, 3, 0, 0, b, d, wc);
    n_cmp++; if (b !== exp_busy(3)) begin n_err++; $display("FAIL wr_busy: got %0d want %0d", b, exp_busy(3)); end
    n_cmp++; if (d !== 1 || wc !== 1) begin n_err++; $display("FAIL wr_den_pulse: den=%0d dwe=%0d want 1/1", d, wc); end
    n_cmp++; if (last_addr !== 7'h41 || last_di !== 16'h1234) begin
      n_err++; $display("FAIL wr_drp_bus: addr=%h di=%h want 41/1234", last_addr, last_di); end
    n_cmp++; if (tgt_mem[7'h41] !== 16'h1234) begin n_err++; $display("FAIL wr_target: got %h want 1234", tgt_mem[7'h41]); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL wr_stat: got %h want 2", v); end
    bus_rd(DRP_CMD, v);
    n_cmp++; if (v !== 32'h141) begin n_err++; $display("FAIL wr_cmd_rb: got %h want 141", v); end
  endtask

  task automatic test_read();
    int b, d, wc;
    logic [31:0] v;
    data_wr(4'h3, 32'h0000_BEEF);
    model_txn(7'h41, 1'b1, 2);
    launch_and_wait(7'h41, 1'b1, 2, 0, 0, b, d, wc);
    model_txn(7'h41, 1'b0, 4);
    launch_and_wait(7'h41, 1'b0, 4, 0, 0, b, d, wc);
    n_cmp++; if (wc !== 0 || d !== 1) begin n_err++; $display("FAIL rd_dwe: dwe=%0d den=%0d want 0/1", wc, d); end
    bus_rd(DRP_DATA, v);
    n_cmp++; if (v !== 32'h0000_BEEF) begin n_err++; $display("FAIL rd_data: got %h want 0000beef", v); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL rd_stat: got %h want 2", v); end
  endtask

  task automatic test_timeout();
    int b, d, wc;
    logic [31:0] v;
    model_txn(7'h10, 1'b0, NEVER);
    launch_and_wait(7'h10, 1'b0, NEVER, 0, 0, b, d, wc);
    n_cmp++; if (b !== TMO + 1) begin n_err++; $display("FAIL tmo_busy: got %0d want %0d", b, TMO + 1); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL tmo_stat: got %h want 4", v); end
    bus_rd(DRP_DATA, v);
    n_cmp++; if (v !== {16'b0, m_rdata}) begin n_err++; $display("FAIL tmo_data: got %h want %h", v, m_rdata); end
    stray_req++;
    repeat (4) @(negedge clk);
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL tmo_late_drdy: got %h want 4", v); end
  endtask

  task automatic test_collision();
    int b, d, wc;
    logic [31:0] v;
    data_wr(4'h3, 32'h0000_5A5A);
    model_txn(7'h15, 1'b1, 5);
    launch_and_wait(7'h15, 1'b1, 5, 1, 1, b, d, wc);
    n_cmp++; if (d !== 1) begin n_err++; $display("FAIL coll_den: got %0d pulses want 1", d); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'hA) begin n_err++; $display("FAIL coll_stat: got %h want a", v); end
    bus_rd(DRP_CMD, v);
    n_cmp++; if (v !== 32'h115) begin n_err++; $display("FAIL coll_cmd_rb: got %h want 115", v); end
    bus_wr(DRP_STAT, 4'h1, 32'hE);
    m_done = 1'b0; m_tmo = 1'b0; m_coll = 1'b0;
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL coll_clear: got %h want 0", v); end
  endtask

  task automatic test_boundary();
    int b, d, wc;
    logic [31:0] v;
    model_txn(7'h22, 1'b0, TMO);
    launch_and_wait(7'h22, 1'b0, TMO, 3, TMO + 1, b, d, wc);
    n_cmp++; if (b !== TMO + 1) begin n_err++; $display("FAIL bnd_busy: got %0d want %0d", b, TMO + 1); end
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL bnd_drdy_last: got %h want 2", v); end
    bus_rd(DRP_DATA, v);
    n_cmp++; if (v !== {16'b0, m_rdata}) begin n_err++; $display("FAIL bnd_data: got %h want %h", v, m_rdata); end
    model_txn(7'h23, 1'b0, TMO + 1);
    launch_and_wait(7'h23, 1'b0, TMO + 1, 0, 0, b, d, wc);
    repeat (2) @(negedge clk);
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL bnd_drdy_late: got %h want 4", v); end
  endtask

  task automatic test_reset_mid();
    int b, d, wc;
    logic [31:0] v;
    lat = 20;
    bus_wr(DRP_CMD, 4'h1, 32'h0000_0033);
    bus_rd(DRP_CMD, v);
    n_cmp++; if (busy_o !== 1'b1 || v !== 32'h33) begin
      n_err++; $display("FAIL mid_pre: busy=%b cmd=%h want 1/33", busy_o, v); end
    @(negedge clk);
    xreset = 1'b0;
    #1;
    n_cmp++;
    if ({den_o, dwe_o, busy_o} !== 3'b000 || dr !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: den=%b dwe=%b busy=%b dr=%h want 0", den_o, dwe_o, busy_o, dr);
    end
    @(negedge clk);
    xreset = 1'b1;
    model_reset();
    repeat (25) @(negedge clk);
    bus_rd(DRP_STAT, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mid_stat: got %h want 0", v); end
    model_txn(7'h3C, 1'b1, 2);
    launch_and_wait(7'h3C, 1'b1, 2, 0, 0, b, d, wc);
    n_cmp++; if (b !== 3 || tgt_mem[7'h3C] !== 16'h0) begin
      n_err++; $display("FAIL mid_relaunch: busy=%0d tgt=%h want 3/0", b, tgt_mem[7'h3C]); end
    bus_rd(DRP_STAT, v);
    @(negedge clk);
    cs = 1'b1; re = 1'b1; adr = DRP_CMD; rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (dr !== 32'h2) begin n_err++; $display("FAIL rdy_hold: dr=%h want 2", dr); end
    bus_idle();
  endtask

  task automatic test_random();
    int b, d, wc, l, inj, ia, r;
    logic [6:0]  a;
    bit          w;
    logic [3:0]  be, msk;
    logic [31:0] v, rv;
    for (int it = 0; it < 30; it++) begin
      rv = $urandom; be = 4'($urandom_range(0, 15));
      data_wr(be, rv);
      a = 7'($urandom_range(0, 127)); w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 10);
      l = (r < 8) ? r + 1 : (r == 8) ? TMO : (r == 9) ? TMO + 1 : TMO - 1;
      inj = $urandom_range(0, 3);
      ia = (inj == 3) ? exp_busy(l) : 1;
      model_txn(a, w, l);
      launch_and_wait(a, w, l, inj, ia, b, d, wc);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (b !== exp_busy(l) || d !== 1 || wc !== int'(w)) begin
        n_err++; $display("FAIL rnd_txn[%0d]: busy=%0d den=%0d dwe=%0d want %0d/1/%0d",
                          it, b, d, wc, exp_busy(l), int'(w));
      end
      n_cmp++;
      if (last_addr !== a || last_di !== m_di || di_o !== m_di) begin
        n_err++; $display("FAIL rnd_drp[%0d]: addr=%h di@den=%h di=%h want %h/%h", it, last_addr, last_di, di_o, a, m_di);
      end
      bus_rd(DRP_STAT, v);
      n_cmp++; if (v !== m_stat()) begin n_err++; $display("FAIL rnd_stat[%0d]: got %h want %h", it, v, m_stat()); end
      bus_rd(DRP_DATA, v);
      n_cmp++; if (v !== {16'b0, m_rdata}) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", it, v, m_rdata); end
      bus_rd(DRP_CMD, v);
      n_cmp++; if (v !== {23'b0, m_wr, 1'b0, m_addr}) begin
        n_err++; $display("FAIL rnd_cmd[%0d]: got %h want %h", it, v, {23'b0, m_wr, 1'b0, m_addr}); end
      if ($urandom_range(0, 1) == 1) begin
        msk = 4'($urandom_range(0, 15));
        bus_wr(DRP_STAT, 4'h1, {28'b0, msk});
        if (msk[1]) m_done = 1'b0;
        if (msk[2]) m_tmo = 1'b0;
        if (msk[3]) m_coll = 1'b0;
        bus_rd(DRP_STAT, v);
        n_cmp++; if (v !== m_stat()) begin n_err++; $display("FAIL rnd_clr[%0d]: got %h want %h", it, v, m_stat()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_collision();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
